text_buffer_controller: RTL
===========================

TEXT_BUFFER_CONTROLLER -- requirements
Module: text_buffer_controller

Interface
REQ-001 SHALL have parameter ROW_NUMBER, default 16, text rows.
REQ-002 SHALL have parameter COL_NUMBER, default 32, characters per row.
REQ-003 SHALL have parameter BLANK_CHAR, default 8'h20, fill code for cleared/scrolled cells.
REQ-004 SHALL have parameter CURSOR_CHAR, default 8'd128, glyph id substituted at the cursor cell.
REQ-005 SHALL have parameter BLINK_PERIOD, default 12_500_000, clock cycles per cursor blink phase.
REQ-006 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous, active-high.
REQ-008 SHALL have port char_in, input, 8, incoming character or control code.
REQ-009 SHALL have port char_valid, input, 1, char_in is valid this cycle.
REQ-010 SHALL have port char_ready, output, 1, high only in IDLE; a transfer occurs on an edge where char_valid and char_ready are both high.
REQ-011 SHALL have port rd_row, input, 4, display row queried by the pixel encoder.
REQ-012 SHALL have port rd_col, input, 5, display column queried by the pixel encoder.
REQ-013 SHALL have port rd_char, output, 8, character id for (rd_row, rd_col), combinational, zero latency.
REQ-014 SHALL have ports cursor_row (output, 4) and cursor_col (output, 5), current cursor position.
REQ-015 SHALL have port busy, output, 1, high in CLEAR or SCROLL.

Function
REQ-016 SHALL hold a ROW_NUMBER x COL_NUMBER buffer of 8-bit ids, address = row*COL_NUMBER + col (9 bits, 0..511).
REQ-017 SHALL implement states IDLE, CLEAR, SCROLL; char_ready = (state==IDLE); busy = !char_ready.
REQ-018 Printable code 0x20..0x7F accepted: SHALL write it at the cursor on the accepting edge and advance cursor_col by 1.
REQ-019 Printable at col 31: SHALL write, then set col 0, row+1; at row 15 SHALL instead set cursor (15,0) and enter SCROLL.
REQ-020 0x0A (LF): SHALL set col 0, row+1; at row 15 SHALL set (15,0) and enter SCROLL.
REQ-021 0x0D (CR): SHALL set col 0, row unchanged.
REQ-022 0x08 (BS): col>0 -> col-1 and write BLANK_CHAR at new position; col 0 and row>0 -> (row-1, 31) and write BLANK_CHAR there; at (0,0) no effect.
REQ-023 0x0C (FF): SHALL set cursor (0,0) and enter CLEAR.
REQ-024 All other codes SHALL be consumed with no effect on buffer or cursor.
REQ-025 CLEAR: 9-bit sweep counter from 0, writes BLANK_CHAR at one address per cycle, 512 cycles, then IDLE.
REQ-026 SCROLL: 9-bit sweep counter from 0; addr 0..479 write mem[addr+32] into mem[addr]; addr 480..511 write BLANK_CHAR; 512 cycles, then IDLE.
REQ-027 char_valid while not ready SHALL be ignored; the source holds char_in until accepted.
REQ-028 Back-to-back acceptance every cycle SHALL be supported in IDLE.
REQ-029 Blink: cycle counter wraps at BLINK_PERIOD-1 and toggles cursor_on on wrap.
REQ-030 rd_char SHALL equal CURSOR_CHAR when state==IDLE, cursor_on==1 and (rd_row,rd_col)==(cursor_row,cursor_col); otherwise the buffer content.

Reset
REQ-031 On reset: cursor (0,0), blink counter 0, cursor_on 1, sweep counter 0, state CLEAR (char_ready 0, busy 1 for 512 cycles after reset deasserts).
REQ-032 Reset asserted mid-CLEAR or mid-SCROLL SHALL abort and restart CLEAR from address 0; buffer contents before reset are not required to survive.

Verification
REQ-033 Reset, wait 512 cycles -> char_ready 1; every cell reads 8'h20 except (0,0) which reads 128 when cursor_on.
REQ-034 Send 'A','B' back-to-back -> cells (0,0)=8'h41, (0,1)=8'h42, cursor (0,2).
REQ-035 Fill to (15,31), send 'Z' -> busy 512 cycles; afterwards row r holds old row r+1, row 15 all 8'h20 except (14,31)=8'h5A, cursor (15,0).
REQ-036 At (3,0) send 0x08 -> cursor (2,31), cell (2,31)=8'h20; at (0,0) send 0x08 -> no change.
REQ-037 Send 0x0C mid-screen, assert reset at sweep address 200 -> CLEAR restarts at 0, cursor (0,0), ready after 512 cycles.
REQ-038 With BLINK_PERIOD=4: rd at cursor alternates 128 and buffer content every 4 cycles; 128 never shown while busy.

Source files
------------

// File: rtl/text_buffer_controller.sv
// Character-cell text buffer: accepts a character stream with basic control codes,
// maintains a blinking cursor and serves zero-latency glyph lookups to a pixel encoder.
module text_buffer_controller #(
    parameter int         ROW_NUMBER   = 16,
    parameter int         COL_NUMBER   = 32,
    parameter logic [7:0] BLANK_CHAR   = 8'h20,
    parameter logic [7:0] CURSOR_CHAR  = 8'd128,
    parameter int         BLINK_PERIOD = 12_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    input  logic [3:0] rd_row,
    input  logic [4:0] rd_col,
    output logic [7:0] rd_char,
    output logic [3:0] cursor_row,
    output logic [4:0] cursor_col,
    output logic       busy
);

    localparam int              DEPTH      = ROW_NUMBER * COL_NUMBER;
    localparam int              AW         = $clog2(DEPTH);
    localparam int              BW         = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
    localparam logic [AW-1:0]   LAST_ADDR  = AW'(DEPTH - 1);
    localparam logic [AW-1:0]   LAST_ROW_A = AW'(DEPTH - COL_NUMBER);
    localparam logic [BW-1:0]   BLINK_LAST = BW'(BLINK_PERIOD - 1);
    localparam logic [3:0]      LAST_ROW   = 4'(ROW_NUMBER - 1);
    localparam logic [4:0]      LAST_COL   = 5'(COL_NUMBER - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, SCROLL} state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] sweep;
    logic [BW-1:0] blink_cnt;
    logic          cursor_on;

    function automatic logic [AW-1:0] cell_addr(input logic [3:0] row, input logic [4:0] col);
        return AW'(row) * AW'(COL_NUMBER) + AW'(col);
    endfunction

    // NOTE: all registered state uses non-blocking assignments so every reader sees pre-edge values.
    // NOTE: the buffer itself is never reset; the CLEAR sweep that reset starts blanks it instead.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CLEAR;
            sweep      <= '0;
            cursor_row <= '0;
            cursor_col <= '0;
            blink_cnt  <= '0;
            cursor_on  <= 1'b1;
        end else begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                cursor_on <= ~cursor_on;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end

            case (state)
                IDLE: begin
                    if (char_valid) begin
                        if (char_in >= 8'h20 && char_in <= 8'h7F) begin
                            mem[cell_addr(cursor_row, cursor_col)] <= char_in;
                            if (cursor_col != LAST_COL) begin
                                cursor_col <= cursor_col + 5'd1;
                            end else begin
                                cursor_col <= '0;
                                if (cursor_row != LAST_ROW) begin
                                    cursor_row <= cursor_row + 4'd1;
                                end else begin
                                    state <= SCROLL;
                                    sweep <= '0;
                                end
                            end
                        end else begin
                            case (char_in)
                                8'h0A: begin
                                    cursor_col <= '0;
                                    if (cursor_row != LAST_ROW) begin
                                        cursor_row <= cursor_row + 4'd1;
                                    end else begin
                                        state <= SCROLL;
                                        sweep <= '0;
                                    end
                                end
                                8'h0D: cursor_col <= '0;
                                8'h08: begin
                                    // Backspace erases the cell it lands on; it stops at the home cell.
                                    if (cursor_col != '0) begin
                                        cursor_col <= cursor_col - 5'd1;
                                        mem[cell_addr(cursor_row, cursor_col - 5'd1)] <= BLANK_CHAR;
                                    end else if (cursor_row != '0) begin
                                        cursor_row <= cursor_row - 4'd1;
                                        cursor_col <= LAST_COL;
                                        mem[cell_addr(cursor_row - 4'd1, LAST_COL)] <= BLANK_CHAR;
                                    end
                                end
                                8'h0C: begin
                                    cursor_row <= '0;
                                    cursor_col <= '0;
                                    state      <= CLEAR;
                                    sweep      <= '0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                CLEAR: begin
                    mem[sweep] <= BLANK_CHAR;
                    if (sweep == LAST_ADDR) begin
                        state <= IDLE;
                        sweep <= '0;
                    end else begin
                        sweep <= sweep + AW'(1);
                    end
                end
                SCROLL: begin
                    // Each cell takes the one directly below it; the bottom row is refilled blank.
                    if (sweep < LAST_ROW_A) begin
                        mem[sweep] <= mem[sweep + AW'(COL_NUMBER)];
                    end else begin
                        mem[sweep] <= BLANK_CHAR;
                    end
                    if (sweep == LAST_ADDR) begin
                        state <= IDLE;
                        sweep <= '0;
                    end else begin
                        sweep <= sweep + AW'(1);
                    end
                end
                default: begin
                    state <= CLEAR;
                    sweep <= '0;
                end
            endcase
        end
    end

    assign char_ready = (state == IDLE);
    assign busy       = ~char_ready;

    // The cursor glyph is suppressed during sweeps so a half-moved screen never shows it.
    assign rd_char = (char_ready && cursor_on && rd_row == cursor_row && rd_col == cursor_col)
                   ? CURSOR_CHAR : mem[cell_addr(rd_row, rd_col)];

endmodule
